movimenta_asteroides: RTL and testbench
=======================================

Name: movimenta_asteroides

Overview:
- Datapath+FSM that advances every active asteroid one grid step per request.
- Sits directly downstream of the asteroid/shot coordinator FSM:
  - consumes its one-cycle sinal_movimenta_asteroides pulse;
  - returns the fim_move_asteroides pulse that coordinator waits on.
- Walks the asteroid table in an external synchronous-read RAM and writes back updated positions with toroidal wrap-around.

Parameters:
- N_AST, 16, number of asteroid table entries (power of 2, ≥2).
- COORD_W, 4, width of each coordinate.
- GRID_MAX, 15, largest legal coordinate; valid range 0..GRID_MAX, GRID_MAX ≤ 2^COORD_W−1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sinal_movimenta_asteroides  in  1  start pulse from coordinator.
- mem_addr  out  log2(N_AST)  table address, shared by read and write.
- mem_rdata  in  2*COORD_W+4  entry read; valid 1 cycle after mem_addr.
- mem_wdata  out  2*COORD_W+4  updated entry.
- mem_we  out  1  write strobe.
- fim_move_asteroides  out  1  one-cycle done pulse.
- ocupado  out  1  high while a pass is running.
- num_ativos  out  log2(N_AST)+1  valid entries seen in last completed pass.
- db_estado_movimenta_asteroides  out  3  current state code.

Behaviour:
- Entry format, MSB→LSB: valid[1] | dir[3] | y[COORD_W] | x[COORD_W].
- dir encoding, as (dx,dy); y grows downward:
  - 0 N (0,−1), 1 NE (+1,−1), 2 E (+1,0), 3 SE (+1,+1)
  - 4 S (0,+1), 5 SW (−1,+1), 6 W (−1,0), 7 NW (−1,−1)
- Wrap rule, applied independently to x and y:
  - +1 from GRID_MAX → 0.
  - −1 from 0 → GRID_MAX.
  - Explicit compare; modular overflow is not relied on.
- States, with db code:
  - ocioso 0: ocupado=0.
    - On start: clear idx and active-count, go le.
  - le 1: drive mem_addr=idx → espera_leitura.
  - espera_leitura 2: capture mem_rdata into entry register → calcula.
  - calcula 3:
    - valid=1: compute new x/y, increment active-count → escreve.
    - valid=0: → proximo; no write.
  - escreve 4: mem_we=1, mem_addr=idx, mem_wdata = entry with new x/y; valid and dir unchanged → proximo.
  - proximo 5:
    - idx==N_AST−1: → fim.
    - Otherwise: idx++, → le.
  - fim 6: fim_move_asteroides=1, num_ativos←active-count, ocupado=0 → ocioso.
- Outputs:
  - mem_we is high only in escreve.
  - mem_addr holds idx in all states.
  - ocupado is high in states 1–5.
- Latency:
  - Valid entry: 5 cycles; invalid entry: 4 cycles.
  - Start pulse at cycle T gives fim at T+1+Σ(per-entry) cycles.
  - Full table (16 valid): fim at T+81.
- Start while ocupado=1: ignored, no restart, no queueing.
- Start in the same cycle as fim: ignored; the coordinator never issues it.
- Empty table (all invalid): no writes; fim after N_AST*4+1 cycles; num_ativos=0.
- Reset values:
  - state=ocioso, idx=0, count=0, num_ativos=0.
  - All outputs 0.
- Reset mid-pass:
  - Aborts immediately; no further writes.
  - Entries already written stay moved.
  - No fim pulse.

Decomposition:
- Shared package holds:
  - direction codes DIR_N..DIR_NW;
  - entry field offsets/widths (X_LSB, Y_LSB, DIR_LSB, VALID_BIT);
  - state codes.
- One natural sub-module: passo_coordenada. Combinational, COORD_W/GRID_MAX params; inputs coord and delta ∈{−1,0,+1}; output wrapped coord. Instantiated twice, for x and y.
- FSM and index counter live in the top module.

Test Plan:
- Single asteroid, entry 0 = valid, E, x=3, y=5; rest invalid; pulse start → one write to addr 0 with x=4, y=5; fim at T+5+15*4+1=T+66; num_ativos=1.
- Wrap:
  - entry 2 NE at (15,0) → written (0,15).
  - entry 7 SW at (0,15) → written (15,0).
  - dir/valid bits unchanged.
- All 16 valid, each dir 0..7 twice at (8,8) → 16 writes, correct neighbours of (8,8), fim at T+81, num_ativos=16.
- Start re-pulsed at cycles T+10 and T+40 → single pass, exactly one fim, no duplicate writes.
- Assert reset at T+20 of a full pass → outputs 0 within the same cycle; entries 0–3 moved, 4–15 untouched; no fim; subsequent start runs normally.
- Empty table → mem_we never asserted, fim at T+65, num_ativos=0.

Source files
------------

// File: rtl/movimenta_asteroides_pkg.sv
// movimenta_asteroides_pkg: direction codes, state codes and asteroid entry layout
// shared by the asteroid mover and its coordinate stepper.
package movimenta_asteroides_pkg;

    typedef enum logic [2:0] {
        DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } dir_t;

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        LE             = 3'd1,
        ESPERA_LEITURA = 3'd2,
        CALCULA        = 3'd3,
        ESCREVE        = 3'd4,
        PROXIMO        = 3'd5,
        FIM            = 3'd6
    } estado_t;

    // Entry layout, MSB to LSB: valid | dir[2:0] | y | x
    localparam int X_LSB = 0;
    function automatic int y_lsb(input int coord_w);
        return coord_w;
    endfunction
    function automatic int dir_lsb(input int coord_w);
        return 2 * coord_w;
    endfunction
    function automatic int valid_bit(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    function automatic logic signed [1:0] delta_x(input dir_t d);
        return (d == DIR_N || d == DIR_S) ? 2'sd0 :
               (d inside {DIR_NE, DIR_E, DIR_SE}) ? 2'sd1 : -2'sd1;
    endfunction

    // y grows downward, so north is -1
    function automatic logic signed [1:0] delta_y(input dir_t d);
        return (d == DIR_E || d == DIR_W) ? 2'sd0 :
               (d inside {DIR_SE, DIR_S, DIR_SW}) ? 2'sd1 : -2'sd1;
    endfunction

endpackage

// File: rtl/movimenta_asteroides_passo_coordenada.sv
// passo_coordenada: moves one coordinate by -1/0/+1 with toroidal wrap at 0 and GRID_MAX.
module passo_coordenada #(
    parameter int COORD_W  = 4,
    parameter int GRID_MAX = 15
) (
    input  logic [COORD_W-1:0] coord,
    input  logic signed [1:0]  delta,
    output logic [COORD_W-1:0] coord_nova
);

    localparam logic [COORD_W-1:0] MAXC = COORD_W'(GRID_MAX);

    always_comb
        coord_nova = (delta == 2'sd1)  ? ((coord == MAXC) ? '0 : coord + COORD_W'(1)) :
                     (delta == -2'sd1) ? ((coord == '0) ? MAXC : coord - COORD_W'(1)) :
                     coord;

endmodule

// File: rtl/movimenta_asteroides.sv
// movimenta_asteroides: walks the asteroid table once per start pulse, moving every
// valid entry one grid step in its direction and writing it back in place.
module movimenta_asteroides
    import movimenta_asteroides_pkg::*;
#(
    parameter int N_AST    = 16,
    parameter int COORD_W  = 4,
    parameter int GRID_MAX = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sinal_movimenta_asteroides,
    output logic [$clog2(N_AST)-1:0]   mem_addr,
    input  logic [2*COORD_W+3:0]       mem_rdata,
    output logic [2*COORD_W+3:0]       mem_wdata,
    output logic                       mem_we,
    output logic                       fim_move_asteroides,
    output logic                       ocupado,
    output logic [$clog2(N_AST):0]     num_ativos,
    output logic [2:0]                 db_estado_movimenta_asteroides
);

    localparam int AW        = $clog2(N_AST);
    localparam int EW        = 2 * COORD_W + 4;
    localparam int Y_LSB     = y_lsb(COORD_W);
    localparam int DIR_LSB   = dir_lsb(COORD_W);
    localparam int VALID_BIT = valid_bit(COORD_W);
    localparam logic [AW-1:0] ULTIMO = AW'(N_AST - 1);

    estado_t              estado;
    logic [AW-1:0]        idx;
    logic [AW:0]          contagem;
    logic [EW-1:0]        entrada;
    logic [COORD_W-1:0]   x_novo, y_novo, x_passo, y_passo;
    dir_t                 dir;

    assign dir = dir_t'(entrada[DIR_LSB +: 3]);

    passo_coordenada #(.COORD_W(COORD_W), .GRID_MAX(GRID_MAX)) u_passo_x (
        .coord      (entrada[X_LSB +: COORD_W]),
        .delta      (delta_x(dir)),
        .coord_nova (x_passo)
    );

    passo_coordenada #(.COORD_W(COORD_W), .GRID_MAX(GRID_MAX)) u_passo_y (
        .coord      (entrada[Y_LSB +: COORD_W]),
        .delta      (delta_y(dir)),
        .coord_nova (y_passo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            idx        <= '0;
            contagem   <= '0;
            num_ativos <= '0;
            entrada    <= '0;
            x_novo     <= '0;
            y_novo     <= '0;
        end else begin
            case (estado)
                OCIOSO:
                    if (sinal_movimenta_asteroides) begin
                        idx      <= '0;
                        contagem <= '0;
                        estado   <= LE;
                    end
                LE: estado <= ESPERA_LEITURA;
                ESPERA_LEITURA: begin
                    entrada <= mem_rdata;
                    estado  <= CALCULA;
                end
                CALCULA:
                    if (entrada[VALID_BIT]) begin
                        x_novo   <= x_passo;
                        y_novo   <= y_passo;
                        contagem <= contagem + (AW + 1)'(1);
                        estado   <= ESCREVE;
                    end else begin
                        estado <= PROXIMO;
                    end
                ESCREVE: estado <= PROXIMO;
                PROXIMO:
                    if (idx == ULTIMO) begin
                        estado <= FIM;
                    end else begin
                        idx    <= idx + AW'(1);
                        estado <= LE;
                    end
                FIM: begin
                    num_ativos <= contagem;
                    estado     <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    // Outputs decode straight from registers, so an async reset clears them at once.
    assign mem_addr                       = idx;
    assign mem_we                         = (estado == ESCREVE);
    assign mem_wdata                      = {entrada[EW-1:DIR_LSB], y_novo, x_novo};
    assign fim_move_asteroides            = (estado == FIM);
    assign ocupado                        = (estado != OCIOSO) && (estado != FIM);
    assign db_estado_movimenta_asteroides = estado;

endmodule

// File: tb/tb_movimenta_asteroides.sv
// tb_movimenta_asteroides: scoreboard bench; expected write-backs are queued from a
// behavioural model when a pass is launched and matched as the DUT writes.
module tb_movimenta_asteroides;

    logic        clock = 0;
    logic        reset = 1;
    logic        sinal_movimenta_asteroides = 0;
    logic [3:0]  mem_addr;
    logic [11:0] mem_rdata;
    logic [11:0] mem_wdata;
    logic        mem_we;
    logic        fim_move_asteroides;
    logic        ocupado;
    logic [4:0]  num_ativos;
    logic [2:0]  db_estado_movimenta_asteroides;

    movimenta_asteroides dut (
        .clock                          (clock),
        .reset                          (reset),
        .sinal_movimenta_asteroides     (sinal_movimenta_asteroides),
        .mem_addr                       (mem_addr),
        .mem_rdata                      (mem_rdata),
        .mem_wdata                      (mem_wdata),
        .mem_we                         (mem_we),
        .fim_move_asteroides            (fim_move_asteroides),
        .ocupado                        (ocupado),
        .num_ativos                     (num_ativos),
        .db_estado_movimenta_asteroides (db_estado_movimenta_asteroides)
    );

    always #5 clock = ~clock;

    logic [11:0] mem [16];
    logic [11:0] tbl [16];
    logic [11:0] exp_img [16];
    logic [11:0] pre_img [16];
    logic        load = 0;
    logic [15:0] sb [$];
    int          cyc = 0;
    int          fims = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (load) mem <= tbl;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (fim_move_asteroides) fims++;
        if (mem_we) begin
            if (sb.size() == 0) check("extra_write", {mem_addr, mem_wdata}, 32'hFFFF);
            else check("write", {mem_addr, mem_wdata}, sb.pop_front());
        end
    end

    function automatic logic [3:0] wrap(input logic [3:0] c, input int d);
        if (d > 0) return (c == 4'd15) ? 4'd0 : c + 4'd1;
        if (d < 0) return (c == 4'd0) ? 4'd15 : c - 4'd1;
        return c;
    endfunction

    function automatic logic [11:0] mk(input bit v, input int d, input int x, input int y);
        logic [2:0] dd;
        logic [3:0] xx, yy;
        dd = 3'(d); xx = 4'(x); yy = 4'(y);
        return {v, dd, yy, xx};
    endfunction

    // Model: queue expected writes, build expected image, return latency and count.
    task automatic prepare(output int lat, output int cnt);
        int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        int dys [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
        logic [11:0] e, n;
        lat = 1; cnt = 0;
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            e = mem[i];
            pre_img[i] = e;
            if (e[11]) begin
                n = {e[11:8], wrap(e[7:4], dys[e[10:8]]), wrap(e[3:0], dxs[e[10:8]])};
                sb.push_back({4'(i), n});
                exp_img[i] = n;
                lat += 5; cnt++;
            end else begin
                exp_img[i] = e;
                lat += 4;
            end
        end
    endtask

    task automatic load_table();
        @(negedge clock); load = 1;
        @(negedge clock); load = 0;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== exp_img[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic run_pass(input string tag, input bit repulse);
        int t0, lat, cnt, f0;
        bit seen;
        prepare(lat, cnt);
        f0 = fims;
        @(negedge clock);
        sinal_movimenta_asteroides = 1;
        t0 = cyc;
        @(negedge clock);
        sinal_movimenta_asteroides = 0;
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            if (fim_move_asteroides) begin
                seen = 1;
                check({tag, "_lat"}, cyc - t0, lat);
            end else begin
                sinal_movimenta_asteroides = repulse && (cyc - t0 == 10 || cyc - t0 == 40);
                @(negedge clock);
            end
        end
        sinal_movimenta_asteroides = 0;
        check({tag, "_fim_seen"}, seen, 1);
        @(negedge clock);
        check({tag, "_num_ativos"}, num_ativos, cnt);
        check({tag, "_ocupado"}, ocupado, 0);
        check({tag, "_pending"}, sb.size(), 0);
        check_mem({tag, "_mem"});
        repeat (50) @(negedge clock);
        check({tag, "_fim_count"}, fims - f0, 1);
    endtask

    initial begin
        int t0, f0, lat, cnt;
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        load = 1;
        repeat (3) @(negedge clock);
        load = 0;
        check("reset_outputs", {mem_we, fim_move_asteroides, ocupado, mem_addr, mem_wdata,
                                num_ativos, db_estado_movimenta_asteroides}, 0);
        reset = 0;
        @(negedge clock);
        check("idle_state", db_estado_movimenta_asteroides, 0);

        tbl[0] = mk(1, 2, 3, 5);
        load_table();
        run_pass("single", 0);
        check("single_entry0", mem[0], mk(1, 2, 4, 5));

        for (int i = 0; i < 16; i++) tbl[i] = '0;
        tbl[2] = mk(1, 1, 15, 0);
        tbl[7] = mk(1, 5, 0, 15);
        load_table();
        run_pass("wrap", 0);
        check("wrap_ne", mem[2], mk(1, 1, 0, 15));
        check("wrap_sw", mem[7], mk(1, 5, 15, 0));

        for (int i = 0; i < 16; i++) tbl[i] = mk(1, i % 8, 8, 8);
        load_table();
        run_pass("full", 0);
        check("full_nw", mem[15], mk(1, 7, 7, 7));

        load_table();
        run_pass("repulse", 1);

        load_table();
        prepare(lat, cnt);
        f0 = fims;
        @(negedge clock);
        sinal_movimenta_asteroides = 1;
        t0 = cyc;
        @(negedge clock);
        sinal_movimenta_asteroides = 0;
        while (cyc - t0 < 20) @(negedge clock);
        reset = 1;
        #1;
        check("midreset_outputs", {mem_we, fim_move_asteroides, ocupado, mem_addr, mem_wdata,
                                   num_ativos, db_estado_movimenta_asteroides}, 0);
        repeat (5) @(negedge clock);
        check("midreset_pending", sb.size(), 12);
        check("midreset_no_fim", fims - f0, 0);
        for (int i = 4; i < 16; i++) exp_img[i] = pre_img[i];
        check_mem("midreset_mem");
        sb.delete();
        reset = 0;
        load_table();
        run_pass("after_reset", 0);

        for (int i = 0; i < 16; i++) tbl[i] = mk(0, i % 8, i, 15 - i);
        load_table();
        run_pass("empty", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
